// File: rtl/axi4_lite_initiator.sv
// ---------------------------------------------------------------------------
// axi4_lite_initiator
//
// AXI4-lite manager that turns a simple command/response handshake into
// single AXI4-lite transactions, one outstanding at a time.
//
// Ports
//   aclk, aresetn                   clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready             command handshake (ready only while idle)
//   cmd_write, cmd_addr,
//   cmd_wdata, cmd_wstrb            command payload (write = 1, read = 0)
//   rsp_valid/rsp_ready             response handshake
//   rsp_write, rsp_rdata, rsp_resp  response payload (rdata is 0 for writes)
//   aw*, w*, b*                     AXI write address / data / response
//   ar*, r*                         AXI read address / data
// ---------------------------------------------------------------------------
module axi4_lite_initiator #(
    parameter int A = 16,
    parameter int N = 4
) (
    input  logic           aclk,
    input  logic           aresetn,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic           cmd_write,
    input  logic [A-1:0]   cmd_addr,
    input  logic [N*8-1:0] cmd_wdata,
    input  logic [N-1:0]   cmd_wstrb,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_write,
    output logic [N*8-1:0] rsp_rdata,
    output logic [1:0]     rsp_resp,
    output logic [A-1:0]   awaddr,
    output logic [2:0]     awprot,
    output logic           awvalid,
    input  logic           awready,
    output logic [N*8-1:0] wdata,
    output logic [N-1:0]   wstrb,
    output logic           wvalid,
    input  logic           wready,
    input  logic [1:0]     bresp,
    input  logic           bvalid,
    output logic           bready,
    output logic [A-1:0]   araddr,
    output logic [2:0]     arprot,
    output logic           arvalid,
    input  logic           arready,
    input  logic [N*8-1:0] rdata,
    input  logic [1:0]     rresp,
    input  logic           rvalid,
    output logic           rready
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WR    = 3'd1;
    localparam logic [2:0] WR_B  = 3'd2;
    localparam logic [2:0] RD_AR = 3'd3;
    localparam logic [2:0] RD_R  = 3'd4;
    localparam logic [2:0] RSP   = 3'd5;

    logic [2:0]     state;
    // Set on the first clock edge after reset release, so cmd_ready stays
    // low while reset is held even though the state already reads IDLE.
    logic           running;
    logic [A-1:0]   addr_q;
    logic [N*8-1:0] wdata_q;
    logic [N-1:0]   wstrb_q;
    logic           aw_done;
    logic           w_done;

    // A channel counts as finished once its valid has dropped or it is
    // completing its handshake on this edge.
    assign aw_done = !awvalid || awready;
    assign w_done  = !wvalid || wready;

    assign cmd_ready = running && (state == IDLE);
    assign bready    = (state == WR_B);
    assign rready    = (state == RD_R);
    assign rsp_valid = (state == RSP);

    // One captured address serves both channels; only one is ever valid.
    assign awaddr = addr_q;
    assign araddr = addr_q;
    assign wdata  = wdata_q;
    assign wstrb  = wstrb_q;
    assign awprot = 3'b000;
    assign arprot = 3'b000;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= IDLE;
            running   <= 1'b0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            arvalid   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= '0;
        end else begin
            running <= 1'b1;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        addr_q <= cmd_addr;
                        if (cmd_write) begin
                            wdata_q <= cmd_wdata;
                            wstrb_q <= cmd_wstrb;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= WR;
                        end else begin
                            arvalid <= 1'b1;
                            state   <= RD_AR;
                        end
                    end
                end
                WR: begin
                    // AW and W complete independently, in either order.
                    if (awvalid && awready) awvalid <= 1'b0;
                    if (wvalid && wready)   wvalid  <= 1'b0;
                    if (aw_done && w_done)  state   <= WR_B;
                end
                WR_B: begin
                    if (bvalid) begin
                        rsp_resp  <= bresp;
                        rsp_write <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= RSP;
                    end
                end
                RD_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        state   <= RD_R;
                    end
                end
                RD_R: begin
                    if (rvalid) begin
                        rsp_rdata <= rdata;
                        rsp_resp  <= rresp;
                        rsp_write <= 1'b0;
                        state     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi4_lite_initiator.md
AXI4_LITE_INITIATOR -- requirements
Module: axi4_lite_initiator

Interface
REQ-001 SHALL have parameter A, default 16: AXI address width in bits.
REQ-002 SHALL have parameter N, default 4: data bus width in bytes (data = N*8 bits).
REQ-003 SHALL have ports:
- aclk  in  1  clock, all logic rising-edge
- aresetn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  A  byte address
- cmd_wdata  in  N*8  write data
- cmd_wstrb  in  N  write byte strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_write  out  1  response belongs to a write
- rsp_rdata  out  N*8  read data (0 for writes)
- rsp_resp  out  2  AXI BRESP/RRESP
- awaddr/awprot/awvalid/awready  out/out/out/in  A/3/1/1  AXI write address channel
- wdata/wstrb/wvalid/wready  out/out/out/in  N*8/N/1/1  AXI write data channel
- bresp/bvalid/bready  in/in/out  2/1/1  AXI write response channel
- araddr/arprot/arvalid/arready  out/out/out/in  A/3/1/1  AXI read address channel
- rdata/rresp/rvalid/rready  in/in/in/out  N*8/2/1/1  AXI read data channel

Function
REQ-004 SHALL be the AXI4-lite manager side, one transaction outstanding at a time.
REQ-005 SHALL implement FSM states IDLE, WR (AW/W), WR_B, RD_AR, RD_R, RSP.
REQ-006 cmd_ready SHALL equal 1 only in IDLE; a command is accepted on a cycle with cmd_valid & cmd_ready.
REQ-007 On accepting a write: capture addr/wdata/wstrb; next cycle awvalid = wvalid = 1, state WR.
REQ-008 In WR, awvalid SHALL drop the cycle after awvalid & awready and wvalid SHALL drop the cycle after wvalid & wready, each independently; when both handshakes are done (same or different cycles), go to WR_B.
REQ-009 AWVALID/WVALID, once asserted, SHALL NOT deassert, and awaddr/wdata/wstrb SHALL NOT change, until their handshake completes.
REQ-010 bready SHALL be 1 only in WR_B; on bvalid & bready capture bresp, rsp_write = 1, rsp_rdata = 0, go to RSP.
REQ-011 On accepting a read: capture addr; next cycle arvalid = 1, state RD_AR; on arvalid & arready drop arvalid, go to RD_R.
REQ-012 rready SHALL be 1 only in RD_R; on rvalid & rready capture rdata/rresp, rsp_write = 0, go to RSP.
REQ-013 In RSP, rsp_valid SHALL be 1 and rsp_* stable until rsp_valid & rsp_ready, then go to IDLE; cmd_ready rises the following cycle.
REQ-014 awprot and arprot SHALL be driven 3'b000 at all times.
REQ-015 Minimum latency, zero-wait subordinate and rsp_ready held 1: cmd accept at cycle 0, AW/W valid at 1, B handshake at 2, rsp_valid at 3; same for reads with AR/R.
REQ-016 Response codes SHALL be passed through unmodified; SLVERR/DECERR do not alter sequencing.
REQ-017 cmd_* inputs are ignored outside IDLE; no command is lost or duplicated under any backpressure pattern.
REQ-018 Address and data SHALL be forwarded unaligned/unmodified; no address-width arithmetic performed.

Reset
REQ-019 While aresetn = 0: state IDLE; awvalid, wvalid, arvalid, bready, rready, rsp_valid = 0; cmd_ready = 0; captured registers and rsp_* = 0.
REQ-020 cmd_ready SHALL be 1 from the first rising aclk after aresetn deasserts.
REQ-021 Reset asserted mid-transaction SHALL immediately (asynchronously) drop all valid/ready outputs and abandon the transaction without issuing a response.

Verification
REQ-022 Write 0x04 <- 0xabbabeef, strobes 0xF, zero-wait subordinate -> single AW/W beat with awaddr 0x04, wdata 0xabbabeef; rsp_valid at cycle 3 with rsp_write 1, rsp_resp 0.
REQ-023 Read 0x3c, subordinate returns 0xb19b00b5 OKAY -> araddr 0x3c, rsp_rdata 0xb19b00b5, rsp_resp 0, rsp_write 0.
REQ-024 Write with awready delayed 5 cycles and wready immediate -> wvalid drops after 1 cycle, awvalid held 6 cycles with stable awaddr; bready rises only after both handshakes.
REQ-025 Read returning rresp 2'b10, rsp_ready held 0 for 4 cycles -> rsp_valid, rsp_resp 2'b10 stable for 4 cycles, cmd_ready 0 throughout, 1 cycle after release.
REQ-026 Back-to-back write 0x04 then read 0x04 against a register model -> read returns 0xabbabeef; no overlap between write and read channel activity.
REQ-027 aresetn pulsed low while in WR_B -> bready, rsp_valid 0 immediately; after release cmd_ready 1 and next command completes normally.
